axi4_lite_slave: RTL and testbench
==================================

Name: axi4_lite_slave

Overview:
AXI4-Lite slave CSR block exposing three 32-bit registers to a bus master.
- CONTROL (RW) drives CONTROL_o into the datapath.
- STATUS and FIFO_LEVEL (RO) mirror live FIFO status inputs.
- Sits between the system AXI4-Lite interconnect and a FIFO-based datapath.

Parameters:
ADDR_WIDTH, 12, width of AWADDR/ARADDR (byte address)
DATA_WIDTH, 32, data bus width; WSTRB width = DATA_WIDTH/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  synchronous reset, active-high (asserted = 1) despite the name
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte-lane write enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
fifo_empty_i  in  1  FIFO empty flag
fifo_full_i  in  1  FIFO full flag
fifo_level_i  in  DATA_WIDTH  FIFO occupancy
CONTROL_o  out  DATA_WIDTH  current CONTROL register value

Behaviour:

Reset:
- Reset is synchronous, active-high on ARESETn.
- While reset is asserted: all READY/VALID outputs = 0, BRESP = RRESP = 0, RDATA = 0, CONTROL = 0.
- Reset mid-transaction aborts it; no register update.

Address decode:
- Decode on addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- 0x000 CONTROL: RW.
- 0x004 STATUS: RO, value = {zeros, fifo_full_i (bit1), fifo_empty_i (bit0)}.
- 0x008 FIFO_LEVEL: RO, value = fifo_level_i.
- All other addresses: unmapped.

Write channel:
- AWREADY and WREADY are registered and always pulse together for exactly one cycle.
- The pulse fires when AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0. AW alone or W alone is never accepted.
- Handshake completes on the edge where VALID and READY are both 1. On that edge, latch address/data/strobe.
- CONTROL update: each byte lane i with WSTRB[i]=1 takes WDATA lane i. Lanes with WSTRB[i]=0 are unchanged.
- Writes to STATUS or FIFO_LEVEL have no effect; BRESP = SLVERR (2'b10).
- Writes to unmapped addresses have no effect; BRESP = SLVERR.
- Writes to CONTROL give BRESP = OKAY (2'b00).
- BVALID rises the cycle after the handshake and holds, with BRESP stable, until BREADY=1; clears on that edge.
- No new write is accepted while BVALID=1.

Read channel:
- ARREADY is a registered one-cycle pulse when ARVALID=1, ARREADY=0 and RVALID=0.
- On the AR handshake edge, the addressed value is captured into RDATA. STATUS and FIFO_LEVEL are sampled at that edge.
- RVALID rises the cycle after the handshake and holds, with RDATA/RRESP stable, until RREADY=1; clears on that edge.
- Mapped address: RRESP = OKAY. Unmapped address: RDATA = 0, RRESP = SLVERR.
- No new read is accepted while RVALID=1.

Concurrency and outputs:
- Read and write paths are independent and may be active simultaneously.
- A read of CONTROL in the same cycle as the write handshake returns the pre-write value.
- CONTROL_o = CONTROL register, registered, updating the cycle after the write handshake.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x000 with WSTRB=0xF -> BRESP=OKAY; read 0x000 returns 0xDEADBEEF, RRESP=OKAY; CONTROL_o=0xDEADBEEF.
2. fifo_empty_i=0, fifo_full_i=1; read 0x004 -> 0x00000002, RRESP=OKAY.
3. fifo_level_i=5; read 0x008 -> 0x00000005.
4. Write 0xFFFFFFFF to 0x004 -> BRESP=SLVERR; read 0x004 still 0x00000002.
5. CONTROL=0xDEADBEEF, write 0x11223344 with WSTRB=0x5 -> read 0x000 returns 0xDE22BE44.
6. Read 0x010 (unmapped) -> RDATA=0, RRESP=SLVERR. Hold BREADY/RREADY low for 3 cycles -> BVALID/RVALID and data held stable, no new AWREADY/ARREADY pulse. Assert reset mid-write -> CONTROL=0 and all VALIDs low.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite CSR slave: one RW CONTROL register driving the datapath, plus
// read-only STATUS and FIFO_LEVEL views of the live FIFO flags.
module axi4_lite_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    input  logic                      fifo_empty_i,
    input  logic                      fifo_full_i,
    input  logic [DATA_WIDTH-1:0]     fifo_level_i,
    output logic [DATA_WIDTH-1:0]     CONTROL_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-3:0] IDX_CONTROL = (ADDR_WIDTH-2)'(0);
    localparam logic [ADDR_WIDTH-3:0] IDX_STATUS  = (ADDR_WIDTH-2)'(1);
    localparam logic [ADDR_WIDTH-3:0] IDX_LEVEL   = (ADDR_WIDTH-2)'(2);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshake rule for every channel: a beat transfers on the rising edge
    // where VALID and READY are both 1; VALID holds until that edge.

    logic [DATA_WIDTH-1:0] control_q;
    logic [DATA_WIDTH-1:0] control_next;
    logic [ADDR_WIDTH-3:0] aw_idx;
    logic [ADDR_WIDTH-3:0] ar_idx;
    logic                  aw_hs;
    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_unmapped;
    logic                  unused_addr_bits;

    assign aw_idx    = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign CONTROL_o = control_q;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        control_next = control_q;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (S_AXI_WSTRB[i]) begin
                control_next[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_value    = '0;
        rd_unmapped = 1'b0;
        case (ar_idx)
            IDX_CONTROL: rd_value = control_q;
            IDX_STATUS:  rd_value = {{(DATA_WIDTH-2){1'b0}}, fifo_full_i, fifo_empty_i};
            IDX_LEVEL:   rd_value = fifo_level_i;
            default:     rd_unmapped = 1'b1;
        endcase
    end

    // AW and W are only ever accepted as a pair, and never while a response is pending.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            control_q     <= '0;
        end else begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID) begin
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY  <= 1'b1;
            end
            if (aw_hs) begin
                S_AXI_BVALID <= 1'b1;
                if (aw_idx == IDX_CONTROL) begin
                    control_q   <= control_next;
                    S_AXI_BRESP <= RESP_OKAY;
                end else begin
                    S_AXI_BRESP <= RESP_SLVERR;
                end
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read data is captured at the AR handshake, so CONTROL reads see the pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S_AXI_ARREADY <= 1'b0;
            if (S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID) begin
                S_AXI_ARREADY <= 1'b1;
            end
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_value;
                S_AXI_RRESP  <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave: directed scenarios followed by
// randomized register traffic compared against a register-map model.
module tb_axi4_lite_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [11:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [11:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        fifo_empty_i;
    logic        fifo_full_i;
    logic [31:0] fifo_level_i;
    logic [31:0] CONTROL_o;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axi4_lite_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .fifo_empty_i(fifo_empty_i), .fifo_full_i(fifo_full_i), .fifo_level_i(fifo_level_i),
        .CONTROL_o(CONTROL_o)
    );

    // clock / reset
    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ctrl_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference register map
    function automatic logic [1:0] model_wresp(input logic [11:0] addr);
        return (addr >> 2) == 0 ? OKAY : SLVERR;
    endfunction

    function automatic logic [1:0] model_rresp(input logic [11:0] addr);
        return (addr >> 2) <= 2 ? OKAY : SLVERR;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [11:0] addr);
        case (addr >> 2)
            0:       return ctrl_m;
            1:       return 32'(fifo_full_i) * 2 + 32'(fifo_empty_i);
            2:       return fifo_level_i;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        if ((addr >> 2) == 0) ctrl_m = (ctrl_m & ~mask) | (data & mask);
    endtask

    // drivers
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input int hold);
        bit seen;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) seen = 1;
        end
        if (!seen) begin
            check("aw_ready_timeout", 32'(seen), 32'h1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            return;
        end
        check("wready_paired", 32'(S_AXI_WREADY), 32'h1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) seen = 1;
        end
        check("bvalid_seen", 32'(seen), 32'h1);
        check("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        S_AXI_AWVALID = (hold > 0); S_AXI_WVALID = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            check("hold_no_awready", 32'(S_AXI_AWREADY), 32'h0);
            check("hold_bvalid", 32'(S_AXI_BVALID), 32'h1);
            check("hold_bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bvalid_cleared", 32'(S_AXI_BVALID), 32'h0);
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [1:0] exp_resp, input int hold);
        bit seen;
        logic [31:0] exp_d;
        exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) seen = 1;
        end
        if (!seen) begin
            check("ar_ready_timeout", 32'(seen), 32'h1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) seen = 1;
        end
        check("rvalid_seen", 32'(seen), 32'h1);
        check("rdata", S_AXI_RDATA, exp_d);
        check("rresp", 32'(S_AXI_RRESP), 32'(exp_resp));
        S_AXI_ARVALID = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            check("hold_no_arready", 32'(S_AXI_ARREADY), 32'h0);
            check("hold_rvalid", 32'(S_AXI_RVALID), 32'h1);
            check("hold_rdata", S_AXI_RDATA, exp_d);
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rvalid_cleared", 32'(S_AXI_RVALID), 32'h0);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int hold);
        axi_write(addr, data, strb, model_wresp(addr), hold);
        model_write(addr, data, strb);
        check("control_o", CONTROL_o, ctrl_m);
    endtask

    task automatic do_read(input logic [11:0] addr, input int hold);
        exp_q.push_back(model_rdata(addr));
        axi_read(addr, model_rresp(addr), hold);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'h0);
        check({tag, "_wready"},  32'(S_AXI_WREADY),  32'h0);
        check({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'h0);
        check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'h0);
        check({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'h0);
        check({tag, "_bresp"},   32'(S_AXI_BRESP),   32'h0);
        check({tag, "_rresp"},   32'(S_AXI_RRESP),   32'h0);
        check({tag, "_rdata"},   S_AXI_RDATA,        32'h0);
        check({tag, "_control"}, CONTROL_o,          32'h0);
    endtask

    initial begin
        logic [11:0] addr;
        logic [31:0] old_ctrl;
        ARESETn = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
        S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        fifo_empty_i = 1'b1; fifo_full_i = 1'b0; fifo_level_i = '0;
        ctrl_m = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_idle_outputs("reset");
        ARESETn = 1'b0;

        // directed register-map scenarios
        do_write(12'h000, 32'hDEADBEEF, 4'hF, 0);
        check("ctrl_deadbeef", CONTROL_o, 32'hDEADBEEF);
        do_read(12'h000, 0);
        fifo_empty_i = 1'b0; fifo_full_i = 1'b1;
        do_read(12'h004, 0);
        fifo_level_i = 32'd5;
        do_read(12'h008, 0);
        do_write(12'h004, 32'hFFFFFFFF, 4'hF, 0);
        do_read(12'h004, 0);
        do_write(12'h000, 32'h11223344, 4'h5, 0);
        check("ctrl_partial_strobe", CONTROL_o, 32'hDE22BE44);
        do_read(12'h003, 0);
        do_read(12'h010, 3);
        do_write(12'h010, 32'h0BADF00D, 4'hF, 3);
        do_write(12'h002, 32'hCAFE0000, 4'hC, 3);

        // address-only and data-only requests must never be accepted
        @(negedge ACLK);
        S_AXI_AWADDR = 12'h000; S_AXI_AWVALID = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge ACLK);
            check("aw_alone_no_ready", 32'(S_AXI_AWREADY | S_AXI_WREADY), 32'h0);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
        for (int n = 0; n < 4; n++) begin
            @(negedge ACLK);
            check("w_alone_no_ready", 32'(S_AXI_AWREADY | S_AXI_WREADY), 32'h0);
        end
        S_AXI_WVALID = 1'b0;
        check("ctrl_unchanged_lone", CONTROL_o, ctrl_m);

        // simultaneous write and read of CONTROL: read returns the pre-write value
        old_ctrl = ctrl_m;
        exp_q.push_back(old_ctrl);
        fork
            axi_write(12'h000, 32'h5A5A5A5A, 4'hF, OKAY, 0);
            axi_read(12'h000, OKAY, 0);
        join
        model_write(12'h000, 32'h5A5A5A5A, 4'hF);
        check("ctrl_after_concurrent", CONTROL_o, ctrl_m);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            fifo_empty_i = 1'($urandom_range(0, 1));
            fifo_full_i  = 1'($urandom_range(0, 1));
            fifo_level_i = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    addr = 12'h000;
                2:       addr = 12'h004;
                3:       addr = 12'h008;
                default: addr = 12'($urandom_range(3, 1023) * 4);
            endcase
            addr = addr | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            else
                do_read(addr, int'($urandom_range(0, 2)));
        end

        // reset asserted while a write is mid-handshake
        do_write(12'h000, 32'hA5A5A5A5, 4'hF, 0);
        @(negedge ACLK);
        S_AXI_AWADDR = 12'h000; S_AXI_WDATA = 32'h77777777; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 20 && !S_AXI_AWREADY; n++) @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        ctrl_m = '0;
        check_idle_outputs("midreset");
        ARESETn = 1'b0;
        do_read(12'h000, 0);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
